mem_slot_arbiter: RTL and testbench
===================================

# mem_slot_arbiter

Time-slot arbiter for the single synchronous memory port shared by the CPU and an external requester (program loader / debug port). It decodes the one-hot 5-phase vector from the phase generator. The CPU owns the port in its fetch phase (phase[0]) and its data phase (phase[3]). The external requester gets every other cycle, and every cycle while the CPU is halted (phase == 0). The block also routes read data back to whoever issued the read, and flags protocol errors and starvation.

## Interface
- AW, 16, memory address width
- DW, 16, memory data width
- STARVE_LIM, 64, cycles of ungranted ext_req before `starve` asserts (≥ 2)

- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- phase  in  5  one-hot CPU phase; 0 = halted/idle
- cpu_pc  in  AW  fetch address, used in phase[0]
- cpu_d_en  in  1  CPU data access request, legal only in phase[3]
- cpu_d_we  in  1  CPU data write
- cpu_d_addr  in  AW  CPU data address
- cpu_d_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  read data to CPU
- cpu_rvalid  out  1  cpu_rdata valid this cycle
- ext_req  in  1  external access request, held until granted
- ext_we  in  1  external write
- ext_addr  in  AW  external address
- ext_wdata  in  DW  external write data
- ext_gnt  out  1  request accepted this cycle
- ext_rdata  out  DW  read data to requester
- ext_rvalid  out  1  ext_rdata valid this cycle
- mem_en, mem_we  out  1  memory enable / write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after a read enable
- protocol_err  out  1  sticky: CPU data request outside phase[3], or phase not one-hot/zero
- starve  out  1  ext_req pending ≥ STARVE_LIM cycles without grant

## Operation
- The slot owner is a combinational function of `phase`, which is itself registered upstream.
  - phase[0]: CPU fetch. mem_en=1, mem_we=0, mem_addr=cpu_pc.
  - phase[3] with cpu_d_en=1: CPU data access. mem_en=1, mem_we=cpu_d_we, mem_addr=cpu_d_addr, mem_wdata=cpu_d_wdata.
  - phase[3] with cpu_d_en=0, any of phase[1]/[2]/[4], or phase==0: free slot. ext_gnt=ext_req, and mem_* is driven from ext_*.
  - Free slot with no ext_req: mem_en=0, mem_we=0; mem_addr and mem_wdata hold their last driven values, so no toggling.
- The CPU always wins. ext_gnt is never asserted in a CPU-owned cycle.
- Return tracking: the 2-bit register `last_rd` records who issued a read in the previous cycle: NONE, CPU or EXT. Writes record NONE.
  - cpu_rvalid = (last_rd==CPU); ext_rvalid = (last_rd==EXT).
  - cpu_rdata and ext_rdata both carry mem_rdata directly.
- Starvation counter, saturating:
  - increments each cycle with ext_req=1 and ext_gnt=0;
  - clears on ext_gnt or on ext_req=0;
  - `starve` = (count ≥ STARVE_LIM). It is registered and clears the cycle after the counter clears.
- protocol_err: set on cpu_d_en=1 while phase[3]=0, or on phase having more than one bit set. Cleared only by reset.
  - An illegal cpu_d_en is ignored; the slot stays free.
  - A non-one-hot phase is treated as halted (phase==0) for arbitration.

## Timing
- Reset values: last_rd=NONE, cpu_rvalid=ext_rvalid=0, ext_gnt=0 (phase is 0 in reset; ext_gnt follows ext_req only after reset deasserts), mem_en=mem_we=0, mem_addr=mem_wdata=0, starve=0, protocol_err=0, counter=0.
- Grant latency is zero: ext_gnt is combinational in the request cycle. The requester updates its request on the following edge.
- Read latency is 1 cycle from mem_en with mem_we=0 to rvalid, for both requesters.
  - Fetch data in phase[0] returns while phase[1] is active.
  - Data-phase read data returns during phase[4].
- While halted, back-to-back external accesses are granted every cycle at full throughput.
- The halt → run transition needs no drain. A pending ext read issued in the last halted cycle returns in the first phase[0] cycle; the CPU fetch issued in that cycle returns in the next cycle.
- If reset asserts mid-operation, all registers clear immediately. Any outstanding read return is dropped (no rvalid).

## Test plan
- **Halted loader:** phase=0, ext writes 0xA5A5→addr 0x10, then a read of 0x10 the next cycle. Expect ext_gnt both cycles, mem_we=1 then 0, and ext_rvalid=1 with ext_rdata=0xA5A5 one cycle after the read.
- **Running fetch vs ext:** phase cycling 1,2,4,8,16 with ext_req held. Expect ext_gnt=0 in phase[0], ext_gnt=1 in phase[1]; cpu_rvalid=1 in phase[1] with the data at cpu_pc.
- **Data-phase conflict:** phase[3] with cpu_d_en=1, cpu_d_we=1, ext_req=1. Expect mem_addr=cpu_d_addr and ext_gnt=0. Repeat with cpu_d_en=0: expect ext_gnt=1.
- **Starvation:** STARVE_LIM=4, ext_req held while the test drives a phase pattern that is CPU-owned every cycle. Expect starve=1 after 4 ungranted cycles, then 0 the cycle after the first grant.
- **Protocol error:** cpu_d_en=1 during phase[1]. Expect protocol_err=1 (sticky), mem_we driven only by ext, no CPU write; reset clears the flag.
- **Reset mid-read:** issue an ext read, then assert n_rst before the return edge. Expect ext_rvalid=0, all outputs at their reset values immediately.

Source files
------------

// File: rtl/mem_slot_arbiter.sv
// Time-slot arbiter for the single memory port shared by the CPU and an external requester.
// CPU owns fetch (phase[0]) and data (phase[3]) slots; every other cycle goes to the requester.
module mem_slot_arbiter #(
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 16,
  parameter int unsigned STARVE_LIM = 64
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [4:0]    phase,
  input  logic [AW-1:0] cpu_pc,
  input  logic          cpu_d_en,
  input  logic          cpu_d_we,
  input  logic [AW-1:0] cpu_d_addr,
  input  logic [DW-1:0] cpu_d_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          protocol_err,
  output logic          starve
);

  localparam int unsigned CntW = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    RdNone = 2'd0,
    RdCpu  = 2'd1,
    RdExt  = 2'd2
  } rd_src_e;

  rd_src_e         last_rd_q, last_rd_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            starve_q, starve_d;
  logic            err_q, err_d;

  logic            multi_hot;
  logic [4:0]      phase_eff;
  logic            cpu_fetch;
  logic            cpu_data;
  logic            ext_access;

  // A non-one-hot phase is arbitrated as if the CPU were halted.
  assign multi_hot = |(phase & (phase - 5'd1));
  assign phase_eff = multi_hot ? 5'd0 : phase;
  assign cpu_fetch = phase_eff[0];
  assign cpu_data  = phase_eff[3] & cpu_d_en;

  // Gated by n_rst so nothing is granted or driven while reset is held.
  assign ext_access = n_rst & ~cpu_fetch & ~cpu_data & ext_req;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    last_rd_d = RdNone;
    if (n_rst) begin
      if (cpu_fetch) begin
        mem_en    = 1'b1;
        addr_d    = cpu_pc;
        last_rd_d = RdCpu;
      end else if (cpu_data) begin
        mem_en    = 1'b1;
        mem_we    = cpu_d_we;
        addr_d    = cpu_d_addr;
        wdata_d   = cpu_d_wdata;
        last_rd_d = cpu_d_we ? RdNone : RdCpu;
      end else if (ext_access) begin
        mem_en    = 1'b1;
        mem_we    = ext_we;
        addr_d    = ext_addr;
        wdata_d   = ext_wdata;
        last_rd_d = ext_we ? RdNone : RdExt;
      end
    end
  end

  assign ext_gnt   = ext_access;
  assign mem_addr  = addr_d;
  assign mem_wdata = wdata_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!ext_req || ext_access) begin
      cnt_d = '0;
    end else if (cnt_q < CntW'(STARVE_LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign starve_d = (cnt_d >= CntW'(STARVE_LIM));
  assign err_d    = err_q | (cpu_d_en & ~phase[3]) | multi_hot;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_rd_q <= RdNone;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      starve_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      last_rd_q <= last_rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      err_q     <= err_d;
    end
  end

  assign cpu_rvalid   = (last_rd_q == RdCpu);
  assign ext_rvalid   = (last_rd_q == RdExt);
  assign cpu_rdata    = mem_rdata;
  assign ext_rdata    = mem_rdata;
  assign starve       = starve_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Directed self-checking bench for mem_slot_arbiter with a behavioural one-cycle-latency memory.
module tb_mem_slot_arbiter;

  logic        clk;
  logic        n_rst;
  logic [4:0]  phase;
  logic [15:0] cpu_pc;
  logic        cpu_d_en;
  logic        cpu_d_we;
  logic [15:0] cpu_d_addr;
  logic [15:0] cpu_d_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [15:0] ext_wdata;
  logic        ext_gnt;
  logic [15:0] ext_rdata;
  logic        ext_rvalid;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        protocol_err;
  logic        starve;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [15:0] mem [0:65535];

  mem_slot_arbiter #(
    .AW         (16),
    .DW         (16),
    .STARVE_LIM (4)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .phase        (phase),
    .cpu_pc       (cpu_pc),
    .cpu_d_en     (cpu_d_en),
    .cpu_d_we     (cpu_d_we),
    .cpu_d_addr   (cpu_d_addr),
    .cpu_d_wdata  (cpu_d_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_rvalid   (cpu_rvalid),
    .ext_req      (ext_req),
    .ext_we       (ext_we),
    .ext_addr     (ext_addr),
    .ext_wdata    (ext_wdata),
    .ext_gnt      (ext_gnt),
    .ext_rdata    (ext_rdata),
    .ext_rvalid   (ext_rvalid),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .protocol_err (protocol_err),
    .starve       (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    n_rst = 1'b0; phase = 5'd0; cpu_pc = 16'h0; cpu_d_en = 1'b0; cpu_d_we = 1'b0;
    cpu_d_addr = 16'h0; cpu_d_wdata = 16'h0;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0033; ext_wdata = 16'h7777;
    mem_rdata = 16'h0;

    // Reset state, with a request pending that must not be granted
    next_cycle();
    chk("rst_ext_gnt", ext_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_ext_rvalid", ext_rvalid, 0);
    chk("rst_starve", starve, 0);
    chk("rst_perr", protocol_err, 0);
    next_cycle();

    // Halted loader: write then read back 0x10
    n_rst = 1'b1;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0010; ext_wdata = 16'hA5A5;
    settle();
    chk("ld_wr_gnt", ext_gnt, 1);
    chk("ld_wr_en", mem_en, 1);
    chk("ld_wr_we", mem_we, 1);
    chk("ld_wr_addr", mem_addr, 16'h0010);
    chk("ld_wr_wdata", mem_wdata, 16'hA5A5);
    next_cycle();
    ext_we = 1'b0;
    settle();
    chk("ld_rd_gnt", ext_gnt, 1);
    chk("ld_rd_we", mem_we, 0);
    chk("ld_rd_rvalid_early", ext_rvalid, 0);
    next_cycle();
    ext_req = 1'b0;
    settle();
    chk("ld_rvalid", ext_rvalid, 1);
    chk("ld_rdata", ext_rdata, 16'hA5A5);
    chk("ld_idle_en", mem_en, 0);
    chk("ld_idle_addr_hold", mem_addr, 16'h0010);
    chk("ld_idle_gnt", ext_gnt, 0);

    // Running fetch vs ext
    next_cycle();
    phase = 5'b00001; cpu_pc = 16'h0010;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0020;
    settle();
    chk("run_p0_gnt", ext_gnt, 0);
    chk("run_p0_en", mem_en, 1);
    chk("run_p0_addr", mem_addr, 16'h0010);
    next_cycle();
    phase = 5'b00010;
    settle();
    chk("run_p1_gnt", ext_gnt, 1);
    chk("run_p1_cpu_rvalid", cpu_rvalid, 1);
    chk("run_p1_cpu_rdata", cpu_rdata, 16'hA5A5);
    chk("run_p1_addr", mem_addr, 16'h0020);
    next_cycle();
    phase = 5'b00100; ext_req = 1'b0;
    settle();
    chk("run_p2_ext_rvalid", ext_rvalid, 1);
    chk("run_p2_cpu_rvalid", cpu_rvalid, 0);
    chk("run_p2_en", mem_en, 0);

    // Data-phase conflict
    next_cycle();
    phase = 5'b01000; cpu_d_en = 1'b1; cpu_d_we = 1'b1; cpu_d_addr = 16'h0030;
    cpu_d_wdata = 16'h1234;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0040; ext_wdata = 16'hBEEF;
    settle();
    chk("dp_cpu_addr", mem_addr, 16'h0030);
    chk("dp_cpu_gnt", ext_gnt, 0);
    chk("dp_cpu_we", mem_we, 1);
    chk("dp_cpu_wdata", mem_wdata, 16'h1234);
    next_cycle();
    cpu_d_en = 1'b0;
    settle();
    chk("dp_free_gnt", ext_gnt, 1);
    chk("dp_free_addr", mem_addr, 16'h0040);
    chk("dp_free_wdata", mem_wdata, 16'hBEEF);
    chk("dp_free_perr", protocol_err, 0);
    next_cycle();
    cpu_d_en = 1'b1; cpu_d_we = 1'b0; ext_req = 1'b0;
    settle();
    chk("dp_rd_en", mem_en, 1);
    chk("dp_rd_we", mem_we, 0);
    next_cycle();
    phase = 5'b10000; cpu_d_en = 1'b0;
    settle();
    chk("dp_rd_rvalid", cpu_rvalid, 1);
    chk("dp_rd_rdata", cpu_rdata, 16'h1234);

    // Starvation with STARVE_LIM = 4 under continuous fetch slots
    next_cycle();
    phase = 5'b00001; ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0020;
    settle();
    chk("st_c1", starve, 0);
    next_cycle();
    next_cycle();
    next_cycle();
    settle();
    chk("st_c4", starve, 0);
    next_cycle();
    settle();
    chk("st_c5", starve, 1);
    next_cycle();
    phase = 5'b00010;
    settle();
    chk("st_gnt", ext_gnt, 1);
    chk("st_gnt_starve", starve, 1);
    next_cycle();
    phase = 5'b00100; ext_req = 1'b0;
    settle();
    chk("st_clear", starve, 0);

    // Protocol error: CPU data request outside phase[3]
    next_cycle();
    phase = 5'b00010; cpu_d_en = 1'b1; cpu_d_we = 1'b1; cpu_d_addr = 16'h0050;
    cpu_d_wdata = 16'hDEAD;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0060;
    settle();
    chk("pe_gnt", ext_gnt, 1);
    chk("pe_we", mem_we, 0);
    chk("pe_addr", mem_addr, 16'h0060);
    chk("pe_not_yet", protocol_err, 0);
    next_cycle();
    phase = 5'b00100; cpu_d_en = 1'b0; ext_req = 1'b0;
    settle();
    chk("pe_set", protocol_err, 1);
    next_cycle();
    phase = 5'b01000;
    settle();
    chk("pe_sticky", protocol_err, 1);
    n_rst = 1'b0;
    #1;
    chk("pe_rst_clear", protocol_err, 0);
    next_cycle();

    // Non-one-hot phase arbitrates as halted and flags an error
    n_rst = 1'b1;
    phase = 5'b00011; ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0070;
    settle();
    chk("nh_gnt", ext_gnt, 1);
    chk("nh_addr", mem_addr, 16'h0070);
    next_cycle();

    // Halt -> run: ext read in last halted cycle, then fetch
    phase = 5'b00000; ext_addr = 16'h0010;
    settle();
    chk("nh_perr", protocol_err, 1);
    chk("hr_gnt", ext_gnt, 1);
    next_cycle();
    phase = 5'b00001; cpu_pc = 16'h0030; ext_req = 1'b0;
    settle();
    chk("hr_ext_rvalid", ext_rvalid, 1);
    chk("hr_ext_rdata", ext_rdata, 16'hA5A5);
    chk("hr_fetch_addr", mem_addr, 16'h0030);
    next_cycle();
    phase = 5'b00010;
    settle();
    chk("hr_cpu_rvalid", cpu_rvalid, 1);
    chk("hr_cpu_rdata", cpu_rdata, 16'h1234);
    chk("hr_ext_rvalid_off", ext_rvalid, 0);

    // Reset mid-read drops the return
    next_cycle();
    phase = 5'b00000; ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0010;
    settle();
    chk("mr_gnt", ext_gnt, 1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mr_ext_rvalid", ext_rvalid, 0);
    chk("mr_gnt_rst", ext_gnt, 0);
    chk("mr_en", mem_en, 0);
    chk("mr_addr", mem_addr, 0);
    chk("mr_wdata", mem_wdata, 0);
    chk("mr_perr", protocol_err, 0);
    next_cycle();
    chk("mr_ext_rvalid_edge", ext_rvalid, 0);
    n_rst = 1'b1; ext_req = 1'b0;
    settle();
    chk("mr_after_rvalid", ext_rvalid, 0);
    chk("mr_after_addr", mem_addr, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
